// File: rtl/program_loader_if.sv
// Byte-stream, instruction-memory write and CPU-control signals of the program loader.
// The loader is the slave; the stream source, memory and CPU side together form the master.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   instr_count;

  modport slave (
    input  start, in_byte, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, instr_count
  );

  modport master (
    output start, in_byte, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, instr_count
  );
endinterface

// File: rtl/program_loader.sv
// Loads a header-prefixed stream of 3-byte instructions into instruction memory,
// holding the CPU in reset until the whole program has been written.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  program_loader_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_B2,
    S_B1,
    S_B0,
    S_WR,
    S_DONE
  } state_t;

  // Largest legal header value is the memory depth; 9 bits covers depth 256.
  localparam logic [8:0] DEPTH9 = 9'(1 << ADDR_W);

  state_t            r_state, w_state_next;
  logic [ADDR_W:0]   r_n, w_n_next;
  logic [ADDR_W:0]   r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [15:0]       r_hi, w_hi_next;
  logic [23:0]       r_wdata, w_wdata_next;
  logic              r_err, w_err_next;

  logic              w_ready;
  logic              w_xfer;
  logic              w_hdr_bad;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_ready   = (r_state == S_HDR) || (r_state == S_B2) ||
                     (r_state == S_B1)  || (r_state == S_B0);
  assign w_xfer    = io_bus.in_valid & w_ready;
  assign w_hdr_bad = (io_bus.in_byte == 8'd0) || ({1'b0, io_bus.in_byte} > DEPTH9);
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_hi    <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_n     <= w_n_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_hi    <= w_hi_next;
      r_wdata <= w_wdata_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_hi_next    = r_hi;
    w_wdata_next = r_wdata;
    w_err_next   = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_bus.start) begin
          w_state_next = S_HDR;
          w_cnt_next   = '0;
          w_addr_next  = '0;
        end
      end

      S_HDR: begin
        if (w_xfer) begin
          w_n_next = (ADDR_W+1)'(io_bus.in_byte);
          if (w_hdr_bad) begin
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_B2;
          end
        end
      end

      S_B2: begin
        if (w_xfer) begin
          w_hi_next    = {io_bus.in_byte, r_hi[7:0]};
          w_state_next = S_B1;
        end
      end

      S_B1: begin
        if (w_xfer) begin
          w_hi_next    = {r_hi[15:8], io_bus.in_byte};
          w_state_next = S_B0;
        end
      end

      // The write word is assembled off to the side so mem_wdata only moves on entering WR.
      S_B0: begin
        if (w_xfer) begin
          w_wdata_next = {r_hi, io_bus.in_byte};
          w_state_next = S_WR;
        end
      end

      S_WR: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc == r_n) begin
          w_state_next = S_DONE;
        end else begin
          w_addr_next  = r_addr + 1'b1;
          w_state_next = S_B2;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign io_bus.in_ready    = w_ready;
  assign io_bus.mem_we      = (r_state == S_WR);
  assign io_bus.mem_addr    = r_addr;
  assign io_bus.mem_wdata   = r_wdata;
  assign io_bus.done        = (r_state == S_DONE);
  assign io_bus.cpu_hold    = (r_state != S_DONE);
  assign io_bus.err         = r_err;
  assign io_bus.instr_count = r_cnt;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (ADDR_W=8 and ADDR_W=4) share one stimulus
// path selected by sel; a scoreboard built from the stream contents checks every memory write.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(8)) bus8();
  program_loader_if #(.ADDR_W(4)) bus4();

  program_loader #(.ADDR_W(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus8));
  program_loader #(.ADDR_W(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus4));

  int         sel = 0;
  logic       start_d = 1'b0;
  logic       valid_d = 1'b0;
  logic [7:0] byte_d = 8'd0;

  assign bus8.start    = (sel == 0) ? start_d : 1'b0;
  assign bus8.in_valid = (sel == 0) ? valid_d : 1'b0;
  assign bus8.in_byte  = byte_d;
  assign bus4.start    = (sel == 1) ? start_d : 1'b0;
  assign bus4.in_valid = (sel == 1) ? valid_d : 1'b0;
  assign bus4.in_byte  = byte_d;

  logic        m_ready, m_we, m_hold, m_done, m_err;
  logic [7:0]  m_addr;
  logic [23:0] m_wdata;
  logic [8:0]  m_cnt;

  always_comb begin
    if (sel == 0) begin
      m_ready = bus8.in_ready;
      m_we    = bus8.mem_we;
      m_addr  = bus8.mem_addr;
      m_wdata = bus8.mem_wdata;
      m_hold  = bus8.cpu_hold;
      m_done  = bus8.done;
      m_err   = bus8.err;
      m_cnt   = bus8.instr_count;
    end else begin
      m_ready = bus4.in_ready;
      m_we    = bus4.mem_we;
      m_addr  = {4'b0, bus4.mem_addr};
      m_wdata = bus4.mem_wdata;
      m_hold  = bus4.cpu_hold;
      m_done  = bus4.done;
      m_err   = bus4.err;
      m_cnt   = {4'b0, bus4.instr_count};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [23:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] pq[$];
  logic [7:0] sq[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit model_ok(input int aw, input logic [7:0] hdr);
    return (hdr != 8'd0) && (int'(hdr) <= (1 << aw));
  endfunction

  function automatic logic [23:0] model_word(input int i);
    return {pq[3*i], pq[3*i+1], pq[3*i+2]};
  endfunction

  // start cycle + header cycle + 4 cycles per instruction
  function automatic int model_cycles(input int n);
    return 2 + 4 * n;
  endfunction

  function automatic void push_word(input logic [23:0] w);
    pq.push_back(w[23:16]);
    pq.push_back(w[15:8]);
    pq.push_back(w[7:0]);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("hold_is_not_done", m_hold, !m_done);
      if (m_we) begin
        chk("ready_low_in_wr", m_ready, 1'b0);
        chk("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", m_addr, mon_e.a);
          chk("wr_data", m_wdata, mon_e.d);
        end
      end
      if (m_err) err_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, m_ready, 1'b0);
    chk({tag, "_mem_we"}, m_we, 1'b0);
    chk({tag, "_mem_addr"}, m_addr, 8'd0);
    chk({tag, "_mem_wdata"}, m_wdata, 24'd0);
    chk({tag, "_cpu_hold"}, m_hold, 1'b1);
    chk({tag, "_done"}, m_done, 1'b0);
    chk({tag, "_err"}, m_err, 1'b0);
    chk({tag, "_instr_count"}, m_cnt, 9'd0);
  endtask

  // Offers sq byte by byte; returns #1 after the edge that took the last byte.
  task automatic drive_bytes(input bit toggle);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b1;
    bit rdy;
    while (idx < sq.size() && guard < 2000) begin
      byte_d  = sq[idx];
      valid_d = toggle ? ph : 1'b1;
      ph = !ph;
      @(negedge clk);
      rdy = m_ready;
      @(posedge clk);
      #1;
      if (valid_d && rdy) idx++;
      guard++;
    end
    valid_d = 1'b0;
    chk("stream_consumed", idx, sq.size());
  endtask

  task automatic pulse_start();
    start_d = 1'b1;
    @(posedge clk);
    #1 start_d = 1'b0;
  endtask

  task automatic run_load(input int s, input logic [7:0] hdr, input bit toggle);
    int  aw = (s == 0) ? 8 : 4;
    bit  ok;
    int  t_start, t_done, e0, guard;
    wr_t w;
    sel = s;
    ok  = model_ok(aw, hdr);
    if (ok) begin
      for (int i = 0; i < int'(hdr); i++) begin
        w.a = 8'(i);
        w.d = model_word(i);
        exp_q.push_back(w);
      end
    end
    e0 = err_seen;
    pulse_start();
    t_start = cyc;
    chk("hold_after_start", m_hold, 1'b1);
    chk("done_after_start", m_done, 1'b0);
    chk("ready_after_start", m_ready, 1'b1);
    sq.delete();
    sq.push_back(hdr);
    if (ok) foreach (pq[i]) sq.push_back(pq[i]);
    drive_bytes(toggle);
    if (!ok) begin
      chk("err_pulse", m_err, 1'b1);
      chk("err_state_ready", m_ready, 1'b0);
      chk("err_cpu_hold", m_hold, 1'b1);
      chk("err_done", m_done, 1'b0);
      @(posedge clk);
      #1;
      chk("err_one_cycle", m_err, 1'b0);
      chk("err_count", err_seen - e0, 1);
      chk("err_no_writes", m_cnt, 9'd0);
    end else begin
      guard = 0;
      while (!m_done && guard < 20) begin
        @(posedge clk);
        #1;
        guard++;
      end
      t_done = cyc;
      chk("done_reached", m_done, 1'b1);
      chk("cpu_released", m_hold, 1'b0);
      chk("instr_count", m_cnt, {1'b0, hdr});
      chk("writes_left", exp_q.size(), 0);
      chk("no_err", err_seen - e0, 0);
      if (!toggle) chk("load_cycles", t_done - t_start + 1, model_cycles(int'(hdr)));
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    #1 check_reset("rst8");
    sel = 1;
    #1 check_reset("rst4");
    rst_n = 1'b1;
    sel = 0;
    @(posedge clk);
    #1;

    // Model pins, hand-computed
    pq.delete();
    push_word(24'h123456);
    push_word(24'h9ABCDE);
    chk("pin_word0", model_word(0), 24'h123456);
    chk("pin_word1", model_word(1), 24'h9ABCDE);
    chk("pin_cycles_n2", model_cycles(2), 10);
    chk("pin_ok_hdr0", model_ok(8, 8'h00), 1'b0);
    chk("pin_ok_hdr11_aw4", model_ok(4, 8'h11), 1'b0);
    chk("pin_ok_hdr10_aw4", model_ok(4, 8'h10), 1'b1);

    // N=2, in_valid held high, then same load with in_valid toggling (reload from DONE)
    run_load(0, 8'd2, 1'b0);
    run_load(0, 8'd2, 1'b1);

    // Rejected headers
    run_load(0, 8'h00, 1'b0);
    run_load(1, 8'h11, 1'b0);

    // Full-depth load on the 16-entry instance
    pq.delete();
    for (int i = 0; i < 16; i++) push_word({8'(i), ~8'(i), 8'(i) ^ 8'h5A});
    run_load(1, 8'd16, 1'b0);

    // Asynchronous reset after the second byte of the first instruction
    sel = 0;
    pulse_start();
    sq.delete();
    sq.push_back(8'h02);
    sq.push_back(8'h12);
    sq.push_back(8'h34);
    drive_bytes(1'b0);
    chk("pre_reset_ready", m_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    @(posedge clk);
    #1 check_reset("held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pq.delete();
    push_word(24'h123456);
    push_word(24'h9ABCDE);
    run_load(0, 8'd2, 1'b0);

    // Reload from DONE with a single all-ones instruction
    chk("in_done_before_reload", m_done, 1'b1);
    pq.delete();
    push_word(24'hFFFFFF);
    run_load(0, 8'd1, 1'b0);
    chk("final_wdata", m_wdata, 24'hFFFFFF);
    chk("final_addr", m_addr, 8'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Front-end stage that fills the CPU's 24-bit instruction memory before execution. It receives a byte stream over a valid/ready handshake: one header byte giving the instruction count N, then N instructions of three bytes each, most-significant byte first. Each assembled instruction is written to consecutive instruction-memory addresses starting at 0. The CPU is held in reset until the full program has been written.

## Interface
- ADDR_W, 8 — instruction-memory address width; legal range 4..8; depth = 2^ADDR_W
- CLK  input  1  — system clock; all state updates on the rising edge
- reset  input  1  — asynchronous, active-low; clears all state
- start  input  1  — single-cycle pulse that begins a load; sampled only in IDLE and DONE
- in_byte  input  8  — stream data
- in_valid  input  1  — stream data valid
- in_ready  output  1  — loader accepts in_byte this cycle
- mem_we  output  1  — instruction-memory write strobe
- mem_addr  output  ADDR_W  — write address
- mem_wdata  output  24  — assembled instruction {b2, b1, b0}
- cpu_hold  output  1  — drives CPU reset; 1 holds the CPU
- done  output  1  — program loaded; CPU released
- err  output  1  — one-cycle pulse on a rejected header
- instr_count  output  ADDR_W+1  — number of instructions written in the current or last load

## Operation
- Reset values: state = IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, instr_count=0.
- A transfer occurs on a rising edge where in_valid=1 and in_ready=1. in_ready is decoded from the registered state only: 1 in HDR, B2, B1, B0; 0 otherwise.
- IDLE: cpu_hold=1. When start=1, go to HDR, clear instr_count, and set mem_addr=0.
- HDR: on transfer, latch N = in_byte.
  - If N = 0 or N > 2^ADDR_W: pulse err for one cycle and return to IDLE.
  - Otherwise go to B2.
- B2, B1, B0: on each transfer, capture in_byte into bits [23:16], [15:8], [7:0] respectively, then advance to the next state (B0 goes to WR). Without a transfer, the state holds indefinitely; there is no timeout.
- WR: lasts exactly one cycle. mem_we=1 with mem_addr and mem_wdata stable. On the closing edge:
  - instr_count increments.
  - If instr_count+1 = N, go to DONE.
  - Else increment mem_addr and go to B2.
- DONE: done=1, cpu_hold=0. start=1 reloads: set cpu_hold=1 and done=0, then go to HDR as from IDLE.
- start is ignored in HDR, B2, B1, B0, and WR.
- mem_wdata holds its last value outside WR. mem_we is 1 only in WR.
- Arithmetic: mem_addr wraps modulo 2^ADDR_W but never needs to, because N ≤ 2^ADDR_W. instr_count is ADDR_W+1 bits wide, so N = 2^ADDR_W is representable.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronously). Partially written memory is not rolled back. The CPU stays held until a complete load finishes.

## Timing
- start sampled at edge t → HDR from t; in_ready=1 in cycle t+1.
- Byte acceptance: one byte per cycle maximum. The third byte accepted at edge k → mem_we=1 in cycle k..k+1 → memory written at edge k+1.
- Back-to-back: B2 is re-entered at k+1, so the sustained rate is 4 cycles per instruction when in_valid is held high.
- Last write at edge w → done=1 and cpu_hold=0 from w (visible in cycle w..w+1).
- Minimum full load with in_valid always high: 1 (start) + 1 (header) + 4N cycles.
- err is high for exactly the cycle following the rejecting header edge; state is IDLE in that same cycle.

## Test plan
- Reset, then start with N=2 and bytes 0x12,0x34,0x56,0x9A,0xBC,0xDE, in_valid always high → writes 0x123456@0 and 0x9ABCDE@1; done=1 and cpu_hold=0 exactly 10 cycles after start; instr_count=2.
- Same load with in_valid toggling every other cycle → identical writes; no byte lost or duplicated; in_ready never 1 during WR.
- Header 0x00, and header 0x11 with ADDR_W=4 → err pulses one cycle, no mem_we, state IDLE, cpu_hold=1.
- ADDR_W=4, N=16 → 16 writes to addresses 0..15, instr_count=16, no wrap write to 0.
- Drop reset to 0 after the second byte of the first instruction → all outputs at reset values asynchronously; no mem_we; a following full load succeeds.
- In DONE, pulse start and load N=1, 0xFFFFFF → cpu_hold rises the cycle after start; done drops; 0xFFFFFF written @0; done reasserts.
